// File: rtl/multiplier_mac_pipe.sv
// Pipelined multiplier-accumulator: configurable widths, signedness and depth, with ce stall and running sum.
// Optional saturating accumulator when MULT_MAC_SAT_EN is defined; wraps otherwise.
module multiplier_mac_pipe #(
  parameter int ASIZE       = 32,
  parameter int BSIZE       = 16,
  parameter int A_SIGNED    = 0,
  parameter int B_SIGNED    = 0,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_GUARD   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ce,
  input  logic                               in_valid,
  input  logic [ASIZE-1:0]                   a,
  input  logic [BSIZE-1:0]                   b,
  input  logic                               acc_en,
  input  logic                               acc_clr,
  output logic                               out_valid,
  output logic [ASIZE+BSIZE-1:0]             p,
  output logic                               acc_valid,
  output logic [ASIZE+BSIZE+ACC_GUARD-1:0]   acc,
  output logic                               acc_ovf
);

  localparam int PSIZE      = ASIZE + BSIZE;
  localparam int ACCSIZE    = PSIZE + ACC_GUARD;
  localparam bit SIGNED_OUT = (A_SIGNED != 0) || (B_SIGNED != 0);
  // Product chain depth: one stage is spent on the operand register when depth allows.
  localparam int NP         = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  logic [ASIZE:0] w_a_ext;
  logic [BSIZE:0] w_b_ext;
  logic [ASIZE:0] w_op_a;
  logic [BSIZE:0] w_op_b;
  logic           w_op_vld;
  logic           w_op_aen;
  logic           w_op_clr;

  assign w_a_ext = (A_SIGNED != 0) ? {a[ASIZE-1], a} : {1'b0, a};
  assign w_b_ext = (B_SIGNED != 0) ? {b[BSIZE-1], b} : {1'b0, b};

  if (PIPE_STAGES > 1) begin : g_opreg
    logic [ASIZE:0] r_op_a;
    logic [BSIZE:0] r_op_b;
    logic           r_op_vld;
    logic           r_op_aen;
    logic           r_op_clr;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_op_a   <= '0;
        r_op_b   <= '0;
        r_op_vld <= 1'b0;
        r_op_aen <= 1'b0;
        r_op_clr <= 1'b0;
      end else if (ce) begin
        r_op_vld <= in_valid;
        r_op_aen <= in_valid & acc_en;
        r_op_clr <= in_valid & acc_clr;
        if (in_valid) begin
          r_op_a <= w_a_ext;
          r_op_b <= w_b_ext;
        end
      end
    end

    assign w_op_a   = r_op_a;
    assign w_op_b   = r_op_b;
    assign w_op_vld = r_op_vld;
    assign w_op_aen = r_op_aen;
    assign w_op_clr = r_op_clr;
  end else begin : g_opcomb
    assign w_op_a   = w_a_ext;
    assign w_op_b   = w_b_ext;
    assign w_op_vld = in_valid;
    assign w_op_aen = in_valid & acc_en;
    assign w_op_clr = in_valid & acc_clr;
  end

  // Extending both operands to PSIZE makes the low PSIZE product bits exact for any signedness mix.
  logic [PSIZE-1:0] w_mul_a;
  logic [PSIZE-1:0] w_mul_b;
  logic [PSIZE-1:0] w_prod;

  assign w_mul_a = {{(BSIZE-1){w_op_a[ASIZE]}}, w_op_a};
  assign w_mul_b = {{(ASIZE-1){w_op_b[BSIZE]}}, w_op_b};
  assign w_prod  = w_mul_a * w_mul_b;

  logic [PSIZE-1:0] r_prod [NP];
  logic [NP-1:0]    r_vld;
  logic [NP-1:0]    r_aen;
  logic [NP-1:0]    r_clr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) r_prod[i] <= '0;
      r_vld <= '0;
      r_aen <= '0;
      r_clr <= '0;
    end else if (ce) begin
      r_vld[0] <= w_op_vld;
      r_aen[0] <= w_op_aen;
      r_clr[0] <= w_op_clr;
      if (w_op_vld) r_prod[0] <= w_prod;
      for (int i = 1; i < NP; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_aen[i] <= r_aen[i-1];
        r_clr[i] <= r_clr[i-1];
        if (r_vld[i-1]) r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign out_valid = r_vld[NP-1];
  assign p         = r_prod[NP-1];

  logic [ACCSIZE-1:0] r_acc;
  logic               r_acc_vld;
  logic               r_acc_ovf;
  logic [ACCSIZE-1:0] w_p_ext;
  logic [ACCSIZE:0]   w_sum;
  logic               w_ovf_u;
  logic               w_ovf_s;
  logic               w_ovf;
  logic               w_take;
  logic [ACCSIZE-1:0] w_acc_next;

  assign w_p_ext = SIGNED_OUT ? ACCSIZE'($signed(r_prod[NP-1])) : ACCSIZE'(r_prod[NP-1]);
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_p_ext};
  assign w_ovf_u = w_sum[ACCSIZE];
  assign w_ovf_s = (r_acc[ACCSIZE-1] == w_p_ext[ACCSIZE-1]) &&
                   (w_sum[ACCSIZE-1] != r_acc[ACCSIZE-1]);
  assign w_ovf   = SIGNED_OUT ? w_ovf_s : w_ovf_u;
  assign w_take  = r_vld[NP-1] & r_aen[NP-1];

`ifdef MULT_MAC_SAT_EN
  logic [ACCSIZE-1:0] w_sat;
  // Signed overflow direction follows the shared operand sign, i.e. the old acc sign.
  assign w_sat = !SIGNED_OUT       ? {ACCSIZE{1'b1}} :
                 r_acc[ACCSIZE-1]  ? {1'b1, {(ACCSIZE-1){1'b0}}} :
                                     {1'b0, {(ACCSIZE-1){1'b1}}};
  assign w_acc_next = w_ovf ? w_sat : w_sum[ACCSIZE-1:0];
`else
  assign w_acc_next = w_sum[ACCSIZE-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
      r_acc_ovf <= 1'b0;
    end else if (ce) begin
      r_acc_vld <= w_take;
      if (w_take) begin
        if (r_clr[NP-1]) begin
          r_acc     <= w_p_ext;
          r_acc_ovf <= 1'b0;
        end else begin
          r_acc     <= w_acc_next;
          r_acc_ovf <= r_acc_ovf | w_ovf;
        end
      end
    end
  end

  assign acc       = r_acc;
  assign acc_valid = r_acc_vld;
  assign acc_ovf   = r_acc_ovf;

endmodule

// File: tb/tb_multiplier_mac_pipe.sv
// Directed bench for multiplier_mac_pipe: five instances (default, a-signed, both-signed,
// zero guard bits, single-stage) share stimulus; expected values are hand-computed constants.
module tb_multiplier_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, in_valid, acc_en, acc_clr;
  logic [31:0] a;
  logic [15:0] b;

  logic        ov_uu, av_uu, of_uu;
  logic [47:0] p_uu;
  logic [55:0] acc_uu;
  logic        ov_su, av_su, of_su;
  logic [47:0] p_su;
  logic [55:0] acc_su;
  logic        ov_ss, av_ss, of_ss;
  logic [47:0] p_ss;
  logic [55:0] acc_ss;
  logic        ov_g0, av_g0, of_g0;
  logic [47:0] p_g0;
  logic [47:0] acc_g0;
  logic        ov_p1, av_p1, of_p1;
  logic [15:0] p_p1;
  logic [23:0] acc_p1;

  multiplier_mac_pipe u_uu (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_uu), .p(p_uu),
    .acc_valid(av_uu), .acc(acc_uu), .acc_ovf(of_uu));

  multiplier_mac_pipe #(.A_SIGNED(1)) u_su (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_su), .p(p_su),
    .acc_valid(av_su), .acc(acc_su), .acc_ovf(of_su));

  multiplier_mac_pipe #(.A_SIGNED(1), .B_SIGNED(1)) u_ss (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_ss), .p(p_ss),
    .acc_valid(av_ss), .acc(acc_ss), .acc_ovf(of_ss));

  multiplier_mac_pipe #(.ACC_GUARD(0)) u_g0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_g0), .p(p_g0),
    .acc_valid(av_g0), .acc(acc_g0), .acc_ovf(of_g0));

  multiplier_mac_pipe #(.ASIZE(8), .BSIZE(8), .A_SIGNED(1), .B_SIGNED(1), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_p1), .p(p_p1),
    .acc_valid(av_p1), .acc(acc_p1), .acc_ovf(of_p1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [15:0] bv,
                       input logic en, input logic clr);
    in_valid = v; a = av; b = bv; acc_en = en; acc_clr = clr;
  endtask

  localparam logic [47:0] P_FULL = 48'hFFFE_FFFF_0001;

  // Stream with a two-cycle stall while a product is presented
  int          s_ce [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
  int          s_v  [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int          s_a  [9] = '{1, 2, 3, 4, 4, 4, 0, 0, 0};
  int          e_ov [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [47:0] e_p  [9] = '{P_FULL, P_FULL, 48'd2, 48'd2, 48'd2, 48'd4, 48'd6, 48'd8, 48'd8};

  // Accumulate sequence: 3x5 (clr), 2x7, 1x1, then 4x4 (clr)
  int m_a   [4] = '{3, 2, 1, 4};
  int m_b   [4] = '{5, 7, 1, 4};
  int m_clr [4] = '{1, 0, 0, 1};
  int e_av  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  int e_acc [8] = '{0, 0, 0, 15, 29, 30, 16, 16};

  logic [47:0] e_g0_ovf_acc;

  initial begin
`ifdef MULT_MAC_SAT_EN
    e_g0_ovf_acc = 48'hFFFF_FFFF_FFFF;
`else
    e_g0_ovf_acc = 48'hFFFD_FFFE_0002;
`endif
    rst = 1'b0; ce = 1'b1;
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    tick(); tick();
    chk_eq("rst_ov", {63'd0, ov_uu}, 64'd0);
    chk_eq("rst_p", {16'd0, p_uu}, 64'd0);
    chk_eq("rst_acc", {8'd0, acc_uu}, 64'd0);
    chk_eq("rst_ovf", {63'd0, of_uu}, 64'd0);
    rst = 1'b1;
    tick();

    // Full-range products, latency 3 and latency 1
    drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0);
    tick();
    chk_eq("e0_ov_uu", {63'd0, ov_uu}, 64'd0);
    chk_eq("e0_ov_p1", {63'd0, ov_p1}, 64'd1);
    chk_eq("e0_p_p1", {48'd0, p_p1}, 64'd1);
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    tick();
    chk_eq("e1_ov_uu", {63'd0, ov_uu}, 64'd0);
    chk_eq("e1_ov_p1", {63'd0, ov_p1}, 64'd0);
    tick();
    chk_eq("e2_ov_uu", {63'd0, ov_uu}, 64'd1);
    chk_eq("e2_p_uu", {16'd0, p_uu}, {16'd0, P_FULL});
    chk_eq("e2_p_su", {16'd0, p_su}, 64'h0000_FFFF_FFFF_0001);
    chk_eq("e2_p_ss", {16'd0, p_ss}, 64'h0000_0000_0000_0001);
    tick();
    chk_eq("e3_ov_uu", {63'd0, ov_uu}, 64'd0);
    chk_eq("e3_p_hold", {16'd0, p_uu}, {16'd0, P_FULL});
    chk_eq("e3_av_uu", {63'd0, av_uu}, 64'd0);
    tick();

    // Stream with ce stall
    for (int t = 0; t < 9; t++) begin
      ce = (s_ce[t] != 0);
      drive(s_v[t] != 0, 32'(s_a[t]), 16'd2, 1'b0, 1'b0);
      tick();
      chk_eq($sformatf("strm_ov%0d", t), {63'd0, ov_uu}, 64'(e_ov[t]));
      chk_eq($sformatf("strm_p%0d", t), {16'd0, p_uu}, {16'd0, e_p[t]});
    end
    ce = 1'b1;
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    tick();

    // Back-to-back accumulation
    for (int t = 0; t < 8; t++) begin
      if (t < 4) drive(1'b1, 32'(m_a[t]), 16'(m_b[t]), 1'b1, m_clr[t] != 0);
      else       drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
      tick();
      chk_eq($sformatf("mac_av%0d", t), {63'd0, av_uu}, 64'(e_av[t]));
      chk_eq($sformatf("mac_acc%0d", t), {8'd0, acc_uu}, 64'(e_acc[t]));
    end
    chk_eq("mac_ovf", {63'd0, of_uu}, 64'd0);

    // Overflow with no guard bits, then clear
    drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b1); tick();
    drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0); tick();
    drive(1'b1, 32'd1, 16'd1, 1'b1, 1'b1);            tick();
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);            tick();
    chk_eq("ovf1_g0_acc", {16'd0, acc_g0}, {16'd0, P_FULL});
    chk_eq("ovf1_g0_flag", {63'd0, of_g0}, 64'd0);
    chk_eq("ovf1_su_acc", {8'd0, acc_su}, 64'h00FF_FFFF_FFFF_0001);
    tick();
    chk_eq("ovf2_g0_av", {63'd0, av_g0}, 64'd1);
    chk_eq("ovf2_g0_acc", {16'd0, acc_g0}, {16'd0, e_g0_ovf_acc});
    chk_eq("ovf2_g0_flag", {63'd0, of_g0}, 64'd1);
    chk_eq("ovf2_uu_acc", {8'd0, acc_uu}, 64'h0001_FFFD_FFFE_0002);
    chk_eq("ovf2_uu_flag", {63'd0, of_uu}, 64'd0);
    chk_eq("ovf2_su_acc", {8'd0, acc_su}, 64'h00FF_FFFF_FFFE_0002);
    chk_eq("ovf2_su_flag", {63'd0, of_su}, 64'd0);
    chk_eq("ovf2_ss_acc", {8'd0, acc_ss}, 64'd2);
    tick();
    chk_eq("clr_g0_acc", {16'd0, acc_g0}, 64'd1);
    chk_eq("clr_g0_flag", {63'd0, of_g0}, 64'd0);
    chk_eq("clr_uu_acc", {8'd0, acc_uu}, 64'd1);
    tick(); tick();

    // Mid-operation reset with ce low: sticky flag set, samples in flight
    drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b1); tick();
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0);
      tick();
    end
    chk_eq("pre_rst_g0_flag", {63'd0, of_g0}, 64'd1);
    chk_eq("pre_rst_ov", {63'd0, ov_uu}, 64'd1);
    drive(1'b0, 32'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0; ce = 1'b0;
    tick();
    rst = 1'b1; ce = 1'b1;
    chk_eq("mrst_ov", {63'd0, ov_uu}, 64'd0);
    chk_eq("mrst_p", {16'd0, p_uu}, 64'd0);
    chk_eq("mrst_av", {63'd0, av_uu}, 64'd0);
    chk_eq("mrst_acc", {8'd0, acc_uu}, 64'd0);
    chk_eq("mrst_g0_acc", {16'd0, acc_g0}, 64'd0);
    chk_eq("mrst_g0_flag", {63'd0, of_g0}, 64'd0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk_eq($sformatf("flush_ov%0d", t), {63'd0, ov_uu}, 64'd0);
      chk_eq($sformatf("flush_av%0d", t), {63'd0, av_uu}, 64'd0);
      chk_eq($sformatf("flush_g0av%0d", t), {63'd0, av_g0}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
